seg7_scan_driver: RTL and testbench

Multiplexed N-digit seven-segment display driver for the stopwatch and similar front panels. It double-buffers a packed BCD/hex digit vector and time-multiplexes one shared active-low segment bus across NUM_DIGITS active-low digit enables. It adds an optional hex glyph mode and tear-free frame updates to the combinational digit encoder.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_glyph_rom.sv | 39 +++
 rtl/seg7_scan_driver.sv | 137 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment driver.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational digit-code to active-low glyph encoder.
// HEX_MODE selects whether codes 10..15 render as A..F or stay dark.
module seg7_glyph_rom
    import seg7_pkg::*;
#(
    parameter bit HEX_MODE = 1'b0
) (
    input  digit_t     i_code,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    // Look up the glyph; a blank request overrides any code.
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_code)
                4'h0:    o_seg = SEG_0;
                4'h1:    o_seg = SEG_1;
                4'h2:    o_seg = SEG_2;
                4'h3:    o_seg = SEG_3;
                4'h4:    o_seg = SEG_4;
                4'h5:    o_seg = SEG_5;
                4'h6:    o_seg = SEG_6;
                4'h7:    o_seg = SEG_7;
                4'h8:    o_seg = SEG_8;
                4'h9:    o_seg = SEG_9;
                4'hA:    o_seg = HEX_MODE ? SEG_A : SEG_BLANK;
                4'hB:    o_seg = HEX_MODE ? SEG_B : SEG_BLANK;
                4'hC:    o_seg = HEX_MODE ? SEG_C : SEG_BLANK;
                4'hD:    o_seg = HEX_MODE ? SEG_D : SEG_BLANK;
                4'hE:    o_seg = HEX_MODE ? SEG_E : SEG_BLANK;
                4'hF:    o_seg = HEX_MODE ? SEG_F : SEG_BLANK;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with double-buffered digits.
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero suppression
// on the active buffer (digit 0 is never suppressed).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter bit HEX_MODE   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0]              r_pre;
    logic [IDX_W-1:0]              r_idx;
    digit_t [NUM_DIGITS-1:0]       r_pending;
    digit_t [NUM_DIGITS-1:0]       r_active;
    logic                          r_pending_valid;
    logic                          r_lit;
    logic [6:0]                    r_segments;
    logic [NUM_DIGITS-1:0]         r_anodes;
    logic                          r_frame_start;

    logic                          w_tick;
    logic                          w_boundary;
    logic                          w_swap;
    logic [IDX_W-1:0]              w_idx_next;
    digit_t [NUM_DIGITS-1:0]       w_active_next;
    digit_t                        w_code;
    logic                          w_blank;
    logic [6:0]                    w_glyph;

    // Scan timing and the buffer the outputs will reflect after this edge,
    // so digit 0 shows freshly swapped data on the very boundary edge.
    always_comb begin
        w_tick        = (r_pre == PRE_LAST);
        w_boundary    = w_tick && (r_idx == IDX_LAST);
        w_swap        = w_boundary && r_pending_valid;
        w_idx_next    = r_idx;
        if (w_tick) begin
            w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
        w_active_next = w_swap ? r_pending : r_active;
        w_code        = w_active_next[w_idx_next];
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] w_lz;
    logic                  w_zero_run;

    // Leading-zero mask: digit k blanks while it and all higher digits are 0.
    always_comb begin
        w_lz       = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run && (w_active_next[k] == 4'd0);
            w_lz[k]    = w_zero_run;
        end
    end

    assign w_blank = blank_mask[w_idx_next] | w_lz[w_idx_next];
`else
    assign w_blank = blank_mask[w_idx_next];
`endif

    seg7_glyph_rom #(
        .HEX_MODE (HEX_MODE)
    ) u_glyph (
        .i_code  (w_code),
        .i_blank (w_blank),
        .o_seg   (w_glyph)
    );

    // Prescaler and digit index advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            r_idx <= w_idx_next;
        end
    end

    // Double buffer: loads land in pending, frame boundaries promote to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending       <= '0;
            r_active        <= '0;
            r_pending_valid <= 1'b0;
        end else begin
            if (w_swap) begin
                r_active <= r_pending;
            end
            if (load) begin
                r_pending       <= digits_in;
                r_pending_valid <= 1'b1;
            end else if (w_swap) begin
                r_pending_valid <= 1'b0;
            end
        end
    end

    // Registered display outputs; dark until the first scan tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lit         <= 1'b0;
            r_segments    <= SEG_BLANK;
            r_anodes      <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_boundary;
            if (w_tick || r_lit) begin
                r_lit      <= 1'b1;
                r_anodes   <= ~(NUM_DIGITS'(1) << w_idx_next);
                r_segments <= w_glyph;
            end
        end
    end

    assign segments    = r_segments;
    assign anodes      = r_anodes;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: NUM_DIGITS=4, SCAN_DIV=4, with a
// HEX_MODE=0 and a HEX_MODE=1 instance sharing the same stimulus.
module tb_seg7_scan_driver;

`ifdef SEG7_LZ_BLANK_EN
    localparam logic [7:0] LZ_SEG = 8'h7F;
`else
    localparam logic [7:0] LZ_SEG = 8'h40;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_in;
    logic        load;
    logic [3:0]  blank_mask;

    logic [6:0]  seg0, seg1;
    logic [3:0]  an0, an1;
    logic        fs0, fs1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
        .blank_mask(blank_mask), .segments(seg0), .anodes(an0), .frame_start(fs0)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1'b1)) dut_hex (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
        .blank_mask(blank_mask), .segments(seg1), .anodes(an1), .frame_start(fs1)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; digits_in = '0; blank_mask = '0;
        step(3);
        chk("rst_seg", {1'b0, seg0}, 8'h7F);
        chk("rst_an", {4'h0, an0}, 8'h0F);
        chk("rst_fs", {7'h0, fs0}, 8'h00);
        rst_n = 1'b1;

        // First tick lights digit 1 with the zeroed active buffer.
        step(4);
        chk("t1_an", {4'h0, an0}, 8'h0D);
        chk("t1_seg", {1'b0, seg0}, 8'h40);
        chk("t1_fs", {7'h0, fs0}, 8'h00);

        // Load 4321 and scan a full frame.
        load = 1'b1; digits_in = 16'h4321;
        step(1);
        load = 1'b0;
        step(11);
        chk("t2_fs", {7'h0, fs0}, 8'h01);
        chk("t2_an0", {4'h0, an0}, 8'h0E);
        chk("t2_seg0", {1'b0, seg0}, 8'h79);
        step(1);
        chk("t2_fs_pulse", {7'h0, fs0}, 8'h00);
        step(3);
        chk("t2_an1", {4'h0, an0}, 8'h0D);
        chk("t2_seg1", {1'b0, seg0}, 8'h24);
        step(4);
        chk("t2_an2", {4'h0, an0}, 8'h0B);
        chk("t2_seg2", {1'b0, seg0}, 8'h30);
        step(4);
        chk("t2_an3", {4'h0, an0}, 8'h07);
        chk("t2_seg3", {1'b0, seg0}, 8'h19);

        // Load 1111, then 2222 on the boundary cycle itself.
        load = 1'b1; digits_in = 16'h1111;
        step(1);
        load = 1'b0;
        step(2);
        load = 1'b1; digits_in = 16'h2222;
        step(1);
        load = 1'b0;
        chk("t3_fs", {7'h0, fs0}, 8'h01);
        chk("t3_an0", {4'h0, an0}, 8'h0E);
        chk("t3_seg0_a", {1'b0, seg0}, 8'h79);
        step(4);
        chk("t3_seg1_a", {1'b0, seg0}, 8'h79);
        step(12);
        chk("t3_an0_b", {4'h0, an0}, 8'h0E);
        chk("t3_seg0_b", {1'b0, seg0}, 8'h24);

        // Hex digits FA0C on both instances.
        load = 1'b1; digits_in = 16'hFA0C;
        step(1);
        load = 1'b0;
        step(15);
        chk("t4_d0_dec", {1'b0, seg0}, 8'h7F);
        chk("t4_d0_hex", {1'b0, seg1}, 8'h46);
        step(4);
        chk("t4_d1_dec", {1'b0, seg0}, 8'h40);
        chk("t4_d1_hex", {1'b0, seg1}, 8'h40);
        step(4);
        chk("t4_d2_dec", {1'b0, seg0}, 8'h7F);
        chk("t4_d2_hex", {1'b0, seg1}, 8'h08);
        step(4);
        chk("t4_d3_dec", {1'b0, seg0}, 8'h7F);
        chk("t4_d3_hex", {1'b0, seg1}, 8'h0E);
        chk("t4_d3_an", {4'h0, an1}, 8'h07);

        // Blank digit 2 of 8888.
        load = 1'b1; digits_in = 16'h8888; blank_mask = 4'b0100;
        step(1);
        load = 1'b0;
        step(3);
        chk("t5_d0_seg", {1'b0, seg0}, 8'h00);
        chk("t5_d0_an", {4'h0, an0}, 8'h0E);
        step(4);
        chk("t5_d1_seg", {1'b0, seg0}, 8'h00);
        step(4);
        chk("t5_d2_an", {4'h0, an0}, 8'h0B);
        chk("t5_d2_seg", {1'b0, seg0}, 8'h7F);
        chk("t5_d2_seg_hex", {1'b0, seg1}, 8'h7F);
        step(4);
        chk("t5_d3_seg", {1'b0, seg0}, 8'h00);
        chk("t5_d3_an", {4'h0, an0}, 8'h07);
        blank_mask = 4'b0000;

        // Leading zeros with 0070.
        load = 1'b1; digits_in = 16'h0070;
        step(1);
        load = 1'b0;
        step(3);
        chk("t6_d0", {1'b0, seg0}, 8'h40);
        step(4);
        chk("t6_d1", {1'b0, seg0}, 8'h78);
        step(4);
        chk("t6_d2", {1'b0, seg0}, LZ_SEG);
        step(4);
        chk("t6_d3", {1'b0, seg0}, LZ_SEG);

        // Leading zeros with 0000.
        load = 1'b1; digits_in = 16'h0000;
        step(1);
        load = 1'b0;
        step(3);
        chk("t6z_d0", {1'b0, seg0}, 8'h40);
        step(4);
        chk("t6z_d1", {1'b0, seg0}, LZ_SEG);
        step(4);
        chk("t6z_d2", {1'b0, seg0}, LZ_SEG);
        step(4);
        chk("t6z_d3", {1'b0, seg0}, LZ_SEG);

        // Mid-frame asynchronous reset discards a pending 5555.
        step(2);
        load = 1'b1; digits_in = 16'h5555;
        step(1);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_seg", {1'b0, seg0}, 8'h7F);
        chk("ar_an", {4'h0, an0}, 8'h0F);
        chk("ar_fs", {7'h0, fs0}, 8'h00);
        step(3);
        rst_n = 1'b1;
        step(4);
        chk("ar_t1_an", {4'h0, an0}, 8'h0D);
        chk("ar_t1_seg", {1'b0, seg0}, 8'h40);
        step(12);
        chk("ar_fs1", {7'h0, fs0}, 8'h01);
        chk("ar_d0_an", {4'h0, an0}, 8'h0E);
        chk("ar_d0_seg", {1'b0, seg0}, 8'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
